// File: rtl/nmea_coord_to_fixed.sv
// NMEA ddmm.f / dddmm.f ASCII field to signed fixed-point degrees.
// A byte-serial parser feeds a restoring divider; both sides use valid/ready handshakes.
module nmea_coord_to_fixed #(
    parameter int FRAC_DIGITS = 4,
    parameter int FRAC_BITS   = 16,
    parameter int INT_BITS    = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              is_lon,
    input  logic                              sign,
    input  logic [127:0]                      ascii_vec,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0]     deg_q,
    output logic                              out_err
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int              W     = INT_BITS + FRAC_BITS;
    localparam longint unsigned SCALE = pow10(FRAC_DIGITS);
    localparam longint unsigned DVSR  = 60 * SCALE;
    localparam int              DW    = $clog2(DVSR + 1);
    localparam int              NW    = DW + FRAC_BITS + 1;
    localparam int              MFW   = $clog2(SCALE);
    localparam int              QW    = FRAC_BITS + 1;
    localparam int              CNTW  = $clog2(FRAC_BITS + 16);

    typedef enum logic [2:0] {IDLE, PARSE, DIV, FINISH, OUT} state_t;

    state_t           state, state_n;
    logic [127:0]     ascii_r;
    logic             lon_r, sign_r, err;
    logic [CNTW-1:0]  cnt, nd, plen;
    logic [9:0]       dd, maxdeg;
    logic [6:0]       mi;
    logic [MFW-1:0]   mf;
    logic [NW-1:0]    rem, dvs;
    logic [QW-1:0]    q;
    logic [W-1:0]     res;
    logic [7:0]       cur;
    logic             is_digit, range_err;

    always_comb begin
        cur       = ascii_r[127:120];
        is_digit  = (cur >= 8'h30) && (cur <= 8'h39);
        nd        = lon_r ? CNTW'(3) : CNTW'(2);
        plen      = nd + CNTW'(3 + FRAC_DIGITS);
        maxdeg    = lon_r ? 10'd180 : 10'd90;
        range_err = (mi >= 7'd60) || (dd > maxdeg) ||
                    ((dd == maxdeg) && ((mi != '0) || (mf != '0)));
        res       = (W'(dd) << FRAC_BITS) + W'(q);
        if (sign_r) res = -res;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = PARSE;
            end
            // The extra cycle at cnt == plen runs the range checks and loads the divider.
            PARSE:   if (cnt == plen) state_n = (err || range_err) ? FINISH : DIV;
            DIV:     if (cnt == CNTW'(FRAC_BITS)) state_n = FINISH;
            FINISH:  state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ascii_r <= '0;
            lon_r   <= 1'b0;
            sign_r  <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            dd      <= '0;
            mi      <= '0;
            mf      <= '0;
            rem     <= '0;
            dvs     <= '0;
            q       <= '0;
            deg_q   <= '0;
            out_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    ascii_r <= ascii_vec;
                    lon_r   <= is_lon;
                    sign_r  <= sign;
                    err     <= 1'b0;
                    cnt     <= '0;
                    dd      <= '0;
                    mi      <= '0;
                    mf      <= '0;
                end
                PARSE: begin
                    if (cnt < plen) begin
                        cnt     <= cnt + 1'b1;
                        ascii_r <= {ascii_r[119:0], 8'h00};
                        if (cnt == nd + CNTW'(2)) begin
                            if (cur != 8'h2E) err <= 1'b1;
                        end else if (!is_digit) begin
                            err <= 1'b1;
                        end else if (cnt < nd) begin
                            dd <= dd * 10'd10 + 10'(cur[3:0]);
                        end else if (cnt < nd + CNTW'(2)) begin
                            mi <= mi * 7'd10 + 7'(cur[3:0]);
                        end else begin
                            mf <= mf * MFW'(10) + MFW'(cur[3:0]);
                        end
                    end else begin
                        err <= err | range_err;
                        cnt <= '0;
                        q   <= '0;
                        rem <= ((NW'(mi) * NW'(SCALE) + NW'(mf)) << FRAC_BITS) + NW'(DVSR / 2);
                        dvs <= NW'(DVSR) << FRAC_BITS;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    dvs <= dvs >> 1;
                    if (rem >= dvs) begin
                        rem <= rem - dvs;
                        q   <= {q[QW-2:0], 1'b1};
                    end else begin
                        q   <= {q[QW-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    if (err) begin
                        deg_q   <= '0;
                        out_err <= 1'b1;
                    end else begin
                        deg_q   <= res;
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_coord_to_fixed.sv
// Bench for nmea_coord_to_fixed: directed vector table, handshake/reset sequences,
// and random fields checked against an arithmetic reference model.
module tb_nmea_coord_to_fixed;

    localparam int FB = 16;
    localparam int W  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0, in_ready, is_lon = 1'b0, sign = 1'b0;
    logic [127:0]   ascii_vec = '0;
    logic           out_valid, out_ready = 1'b1, out_err;
    logic [W-1:0]   deg_q;

    logic           f5_in_valid = 1'b0, f5_in_ready, f5_out_valid, f5_out_err;
    logic [127:0]   f5_ascii_vec = '0;
    logic [W-1:0]   f5_deg_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nmea_coord_to_fixed dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_lon(is_lon), .sign(sign), .ascii_vec(ascii_vec), .out_valid(out_valid),
        .out_ready(out_ready), .deg_q(deg_q), .out_err(out_err)
    );

    nmea_coord_to_fixed #(.FRAC_DIGITS(5), .FRAC_BITS(16), .INT_BITS(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(f5_in_valid), .in_ready(f5_in_ready),
        .is_lon(1'b0), .sign(1'b0), .ascii_vec(f5_ascii_vec), .out_valid(f5_out_valid),
        .out_ready(1'b1), .deg_q(f5_deg_q), .out_err(f5_out_err)
    );

    typedef struct {
        string      s;
        bit         lon;
        bit         sg;
        logic [31:0] deg;
        bit         err;
        int         lat;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] str2vec(input string s);
        logic [127:0] v = {16{8'h20}};
        for (int k = 0; k < s.len() && k < 16; k++) v[127-8*k -: 8] = s[k];
        return v;
    endfunction

    // Reference: parse the field by its rules, then compute with wide integers.
    function automatic void ref_model(input logic [127:0] v, input bit lon, input bit sg,
                                      input int fd, output logic [31:0] deg, output bit err);
        int nd = lon ? 3 : 2;
        longint unsigned dd = 0, mi = 0, mf = 0, scale = 1, maxd, m, d, q, r;
        logic [7:0] c;
        err = 0;
        for (int k = 0; k < nd + 3 + fd; k++) begin
            c = v[127-8*k -: 8];
            if (k == nd + 2) begin
                if (c != 8'h2E) err = 1;
            end else if (c < 8'h30 || c > 8'h39) begin
                err = 1;
            end else if (k < nd) begin
                dd = dd * 10 + longint'(c - 8'h30);
            end else if (k < nd + 2) begin
                mi = mi * 10 + longint'(c - 8'h30);
            end else begin
                mf = mf * 10 + longint'(c - 8'h30);
            end
        end
        for (int i = 0; i < fd; i++) scale = scale * 10;
        maxd = lon ? 180 : 90;
        if (mi >= 60 || dd > maxd || (dd == maxd && (mi != 0 || mf != 0))) err = 1;
        if (err) begin
            deg = '0;
        end else begin
            m = mi * scale + mf;
            d = 60 * scale;
            q = ((m << FB) + d / 2) / d;
            r = (dd << FB) + q;
            deg = sg ? 32'(-r) : 32'(r);
        end
    endfunction

    function automatic logic [127:0] put_num(input logic [127:0] v, input int pos,
                                             input int val, input int ndig);
        int x = val;
        for (int i = ndig - 1; i >= 0; i--) begin
            v[127-8*(pos+i) -: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    function automatic logic [127:0] rand_field(input bit lon);
        logic [127:0] v;
        int nd = lon ? 3 : 2;
        int maxd = lon ? 180 : 90;
        int sel, dd, mi, mf, pos;
        v   = {$urandom(), $urandom(), $urandom(), $urandom()};
        sel = $urandom_range(0, 9);
        dd  = $urandom_range(0, maxd + 5);
        mi  = (sel == 1) ? $urandom_range(60, 99) : $urandom_range(0, 59);
        mf  = $urandom_range(0, 9999);
        if (sel == 0) begin
            dd = maxd;
            mi = 0;
            mf = $urandom_range(0, 1);
        end
        v = put_num(v, 0, dd, nd);
        v = put_num(v, nd, mi, 2);
        v[127-8*(nd+2) -: 8] = 8'h2E;
        v = put_num(v, nd + 3, mf, 4);
        if (sel == 2) begin
            pos = $urandom_range(0, nd + 6);
            v[127-8*pos -: 8] = 8'($urandom());
        end
        return v;
    endfunction

    task automatic run_conv(input logic [127:0] v, input bit lon, input bit sg,
                            output logic [31:0] d, output logic e, output int lat);
        int n = 0;
        @(negedge clk);
        ascii_vec = v;
        is_lon    = lon;
        sign      = sg;
        in_valid  = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        ascii_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
        is_lon    = ~lon;
        sign      = ~sg;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        d = deg_q;
        e = out_err;
    endtask

    initial begin
        logic [31:0] d, exp_d;
        logic        e;
        bit          exp_e, lon, sg;
        int          lat, n;
        logic [127:0] v;

        tbl[0]  = '{"4807.0380",  0, 0, 32'h00301E07, 0, 28};
        tbl[1]  = '{"01131.0000", 1, 1, 32'hFFF47BBC, 0, 29};
        tbl[2]  = '{"0059.9999",  0, 0, 32'h00010000, 0, 28};
        tbl[3]  = '{"0000.0000",  0, 1, 32'h00000000, 0, 28};
        tbl[4]  = '{"4860.0000",  0, 0, 32'h00000000, 1, 11};
        tbl[5]  = '{"48A7.0380",  0, 0, 32'h00000000, 1, 11};
        tbl[6]  = '{"4807,0380",  0, 0, 32'h00000000, 1, 11};
        tbl[7]  = '{"9100.0000",  0, 0, 32'h00000000, 1, 11};
        tbl[8]  = '{"9000.0000",  0, 0, 32'h005A0000, 0, 28};
        tbl[9]  = '{"18000.0000", 1, 1, 32'hFF4C0000, 0, 29};
        tbl[10] = '{"9000.0001",  0, 0, 32'h00000000, 1, 11};
        tbl[11] = '{"18100.0000", 1, 0, 32'h00000000, 1, 12};

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_deg_q", deg_q, 0);
        check("rst_out_err", out_err, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_conv(str2vec(tbl[i].s), tbl[i].lon, tbl[i].sg, d, e, lat);
            check($sformatf("tbl%0d_deg", i), d, tbl[i].deg);
            check($sformatf("tbl%0d_err", i), e, tbl[i].err);
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            lon = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            v   = rand_field(lon);
            ref_model(v, lon, sg, 4, exp_d, exp_e);
            run_conv(v, lon, sg, d, e, lat);
            check($sformatf("rnd%0d_deg", i), d, exp_d);
            check($sformatf("rnd%0d_err", i), e, exp_e);
            check($sformatf("rnd%0d_lat", i), lat, exp_e ? (lon ? 12 : 11) : (lon ? 29 : 28));
        end

        // Back-pressure, with a second request held by the source throughout.
        @(negedge clk);
        out_ready = 1'b0;
        ascii_vec = str2vec("4807.0380");
        is_lon = 1'b0;
        sign = 1'b0;
        in_valid = 1'b1;
        check("bp_idle_ready", in_ready, 1);
        @(negedge clk);
        ascii_vec = str2vec("01131.0000");
        is_lon = 1'b1;
        sign = 1'b1;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_lat", n, 28);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            check($sformatf("bp_hold%0d_deg", i), deg_q, 32'h00301E07);
            check($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", out_valid, 0);
        check("bp_after_hs_in_ready", in_ready, 1);
        check("bp_after_hs_deg_kept", deg_q, 32'h00301E07);
        @(negedge clk);
        check("bp_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_second_lat", n, 29);
        check("bp_second_deg", deg_q, 32'hFFF47BBC);
        check("bp_second_err", out_err, 0);
        @(negedge clk);

        // Reset in the middle of DIV aborts the request.
        run_conv(str2vec("4807.0380"), 0, 0, d, e, lat);
        check("pre_rst_deg", d, 32'h00301E07);
        @(negedge clk);
        ascii_vec = str2vec("0059.9999");
        is_lon = 1'b0;
        sign = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_deg_q", deg_q, 0);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_output", n, 0);
        run_conv(str2vec("4807.0380"), 0, 0, d, e, lat);
        check("post_rst_deg", d, 32'h00301E07);
        check("post_rst_err", e, 0);
        check("post_rst_lat", lat, 28);

        // Five fraction digits.
        @(negedge clk);
        f5_ascii_vec = str2vec("4807.03800");
        f5_in_valid = 1'b1;
        check("f5_in_ready", f5_in_ready, 1);
        @(negedge clk);
        f5_in_valid = 1'b0;
        f5_ascii_vec = '0;
        n = 0;
        while (!f5_out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("f5_lat", n, 29);
        check("f5_deg", f5_deg_q, 32'h00301E07);
        check("f5_err", f5_out_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
